// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one digit per clock, LSD first,
// with start/busy/done handshake, ten's-complement subtract and invalid-digit flag.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  Sub,
    input  logic [4*DIGITS-1:0]   A,
    input  logic [4*DIGITS-1:0]   B,
    input  logic                  Cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Cout,
    output logic                  invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Returns {carry_out, digit}; in subtract mode b is nine's-complemented.
    function automatic logic [4:0] bcd_step(input logic [3:0] a, input logic [3:0] b,
                                            input logic sub, input logic c);
        logic [3:0] b_eff;
        logic [4:0] s;
        logic [4:0] adj;
        b_eff = sub ? (4'd9 - b) : b;
        s     = {1'b0, a} + {1'b0, b_eff} + {4'd0, c};
        adj   = s + 5'd6;
        if (s > 5'd9) begin
            return {1'b1, adj[3:0]};
        end else begin
            return {1'b0, s[3:0]};
        end
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    res_q, res_d;
    logic            sub_q, sub_d;
    logic            carry_q, carry_d;
    logic            inv_q, inv_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            invalid_q, invalid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [4:0]      step_s;
    logic [W-1:0]    res_shift_s;
    logic            inv_acc_s;

    // Next-state, datapath step and output register values.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        sub_d     = sub_q;
        carry_d   = carry_q;
        inv_d     = inv_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;
        done_d    = 1'b0;

        step_s      = bcd_step(a_q[3:0], b_q[3:0], sub_q, carry_q);
        res_shift_s = (res_q >> 4) | (W'(step_s[3:0]) << (W - 4));
        inv_acc_s   = inv_q | digit_bad(a_q[3:0]) | digit_bad(b_q[3:0]);

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = A;
                    b_d     = B;
                    sub_d   = Sub;
                    carry_d = Sub ? 1'b1 : Cin;
                    cnt_d   = '0;
                    res_d   = '0;
                    inv_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                res_d   = res_shift_s;
                carry_d = step_s[4];
                inv_d   = inv_acc_s;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    state_d   = ST_DONE;
                    sum_d     = res_shift_s;
                    cout_d    = step_s[4];
                    invalid_d = inv_acc_s;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            inv_q     <= 1'b0;
            cnt_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            sub_q     <= sub_d;
            carry_q   <= carry_d;
            inv_q     <= inv_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign Sum     = sum_q;
    assign Cout    = cout_q;
    assign invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder with DIGITS=4.
module tb_bcd_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        Sub;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic        Cout;
    logic        invalid;

    int n_cmp = 0;
    int n_err = 0;

    bcd_serial_adder #(.DIGITS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Sub(Sub), .A(A), .B(B), .Cin(Cin),
        .busy(busy), .done(done), .Sum(Sum), .Cout(Cout), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done; k counts edges after the start edge.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic cin, output int lat, output int bcnt);
        @(negedge clk);
        A = a; B = b; Sub = sub; Cin = cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        bcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; Sub = 1'b0; A = 16'h0; B = 16'h0; Cin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({busy, done, Cout, invalid, Sum} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b Cout=%b invalid=%b Sum=%h, required all 0",
                     busy, done, Cout, invalid, Sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat, bcnt;
        run_op(16'h1234, 16'h5678, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if (lat !== 4) begin n_err++; $display("FAIL add_latency: got %0d, required 4", lat); end
        n_cmp++;
        if (bcnt !== 4) begin n_err++; $display("FAIL add_busy_cycles: got %0d, required 4", bcnt); end
        n_cmp++;
        if ({Cout, invalid, Sum} !== {1'b0, 1'b0, 16'h6912}) begin
            n_err++;
            $display("FAIL add_result: Sum=%h Cout=%b invalid=%b, required 6912 0 0", Sum, Cout, invalid);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL add_single_done: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_carry();
        int lat, bcnt;
        run_op(16'h9999, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL carry_b1: lat=%0d Sum=%h Cout=%b, required lat 4 Sum 0000 Cout 1", lat, Sum, Cout);
        end
        run_op(16'h9999, 16'h0000, 1'b0, 1'b1, lat, bcnt);
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b1, 16'h0000}) begin
            n_err++;
            $display("FAIL carry_cin: lat=%0d Sum=%h Cout=%b, required lat 4 Sum 0000 Cout 1", lat, Sum, Cout);
        end
    endtask

    task automatic test_sub();
        int lat, bcnt;
        run_op(16'h5000, 16'h1234, 1'b1, 1'b0, lat, bcnt);
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b1, 16'h3766}) begin
            n_err++;
            $display("FAIL sub_ge: lat=%0d Sum=%h Cout=%b, required 3766 Cout 1", lat, Sum, Cout);
        end
        // Cin=1 must be ignored in subtract mode.
        run_op(16'h1234, 16'h5000, 1'b1, 1'b1, lat, bcnt);
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b0, 16'h6234}) begin
            n_err++;
            $display("FAIL sub_lt: lat=%0d Sum=%h Cout=%b, required 6234 Cout 0", lat, Sum, Cout);
        end
    endtask

    task automatic test_invalid();
        int lat, bcnt;
        run_op(16'h00A0, 16'h0001, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if ({lat == 4, invalid, Sum} !== {1'b1, 1'b1, 16'h0101}) begin
            n_err++;
            $display("FAIL invalid_set: lat=%0d invalid=%b Sum=%h, required invalid 1 Sum 0101", lat, invalid, Sum);
        end
        run_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if ({lat == 4, invalid, Sum} !== {1'b1, 1'b0, 16'h0005}) begin
            n_err++;
            $display("FAIL invalid_clear: lat=%0d invalid=%b Sum=%h, required invalid 0 Sum 0005", lat, invalid, Sum);
        end
    endtask

    task automatic test_start_ignored();
        int lat;
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        A = 16'h9999; B = 16'h9999; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 2; k < 20; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b0, 16'h3333}) begin
            n_err++;
            $display("FAIL start_ignored: lat=%0d Sum=%h Cout=%b, required lat 4 Sum 3333 Cout 0", lat, Sum, Cout);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL start_ignored_idle: done=%b busy=%b, required 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        int first, second;
        logic sum_moved;
        first = -1; second = -1; sum_moved = 1'b0;
        @(negedge clk);
        A = 16'h0123; B = 16'h0456; Sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 30; k++) begin
            if (done && first < 0) begin
                first = k;
                A = 16'h2500; B = 16'h0500; Sub = 1'b1;
            end else if (done && first >= 0) begin
                second = k;
                break;
            end else if (first >= 0) begin
                start = 1'b0;
                if (Sum !== 16'h0579) sum_moved = 1'b1;
            end
            @(negedge clk);
        end
        start = 1'b0;
        n_cmp++;
        if (first !== 4) begin n_err++; $display("FAIL b2b_first_done: got %0d, required 4", first); end
        n_cmp++;
        if (second - first !== 5) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d, required 5", second - first);
        end
        n_cmp++;
        if (sum_moved !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_sum_hold: changed=%b, required 0 (Sum held at 0579)", sum_moved);
        end
        n_cmp++;
        if ({Cout, Sum} !== {1'b1, 16'h2000}) begin
            n_err++;
            $display("FAIL b2b_second_result: Sum=%h Cout=%b, required 2000 1", Sum, Cout);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bcnt;
        logic saw_done;
        @(negedge clk);
        A = 16'h0999; B = 16'h0111; Sub = 1'b0; Cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, Cout, invalid, Sum} !== 20'h0) begin
            n_err++;
            $display("FAIL abort_outputs: busy=%b done=%b Cout=%b invalid=%b Sum=%h, required all 0",
                     busy, done, Cout, invalid, Sum);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
            if (k == 2) rst_n = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_no_done: activity=%b, required 0", saw_done);
        end
        run_op(16'h0999, 16'h0111, 1'b0, 1'b0, lat, bcnt);
        n_cmp++;
        if ({lat == 4, Cout, Sum} !== {1'b1, 1'b0, 16'h1110}) begin
            n_err++;
            $display("FAIL abort_recover: lat=%0d Sum=%h Cout=%b, required lat 4 Sum 1110 Cout 0", lat, Sum, Cout);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry();
        test_sub();
        test_invalid();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
